// File: rtl/pid_error_tracker.sv
// PID front stage: captures an ADC sample against the setpoint, forms a
// saturated signed error, keeps the current/previous error pair and issues
// one-cycle enable strobes so the derivative and integral stages latch a
// consistent pair.
module pid_error_tracker #(
  parameter int ADC_WIDTH = 8,
  parameter int DECIM     = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 loop_enable,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic [ADC_WIDTH-1:0] setpoint,
  output logic [ADC_WIDTH-1:0] cur_error,
  output logic [ADC_WIDTH-1:0] prev_error,
  output logic                 deriv_enable,
  output logic                 integ_enable,
  output logic                 busy,
  output logic                 overrun
);

  // The raw difference needs one extra bit to hold the full unsigned span.
  localparam int EW = ADC_WIDTH + 1;
  localparam logic signed [EW-1:0] ERR_MAX = {2'b00, {(ADC_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] ERR_MIN = {2'b11, {(ADC_WIDTH-1){1'b0}}};
  localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [ADC_WIDTH-1:0] sample_reg;
  logic [ADC_WIDTH-1:0] setpoint_reg;
  logic [ADC_WIDTH-1:0] cur_error_reg;
  logic [ADC_WIDTH-1:0] prev_error_reg;
  logic                 first_reg;
  logic                 strobe_reg;
  logic                 overrun_reg;
  logic [7:0]           dec_cnt_reg;

  logic                 dec_hit;
  logic                 accept;
  logic                 skip;
  logic                 calc_fire;
  logic                 strobe_next;
  logic                 overrun_set;
  logic signed [EW-1:0] err_wide;
  logic [ADC_WIDTH-1:0] err_sat;

  // Decimation counter only exists when samples are actually thinned out.
  generate
    if (DECIM > 1) begin : g_decim
      // Count discarded samples; cleared on every accepted one or loop stop.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          dec_cnt_reg <= '0;
        end else if (!loop_enable) begin
          dec_cnt_reg <= '0;
        end else if (skip) begin
          dec_cnt_reg <= dec_cnt_reg + 8'd1;
        end else if (accept) begin
          dec_cnt_reg <= '0;
        end
      end
    end else begin : g_no_decim
      assign dec_cnt_reg = '0;
    end
  endgenerate

  assign dec_hit = (dec_cnt_reg >= DEC_LAST);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a stopped loop always parks the tracker in IDLE.
  always_comb begin
    state_next = state_reg;
    if (!loop_enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (adc_valid && dec_hit) state_next = CALC;
        CALC:    state_next = STROBE;
        STROBE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / control decode from the current state.
  always_comb begin
    busy        = (state_reg != IDLE);
    accept      = loop_enable && adc_valid && (state_reg == IDLE) && dec_hit;
    skip        = loop_enable && adc_valid && (state_reg == IDLE) && !dec_hit;
    calc_fire   = loop_enable && (state_reg == CALC);
    strobe_next = loop_enable && (state_reg == STROBE);
    overrun_set = loop_enable && adc_valid && (state_reg != IDLE);
  end

  // Signed error with clamping to the representable ADC_WIDTH range.
  always_comb begin
    err_wide = $signed({1'b0, setpoint_reg}) - $signed({1'b0, sample_reg});
    if (err_wide > ERR_MAX) begin
      err_sat = ERR_MAX[ADC_WIDTH-1:0];
    end else if (err_wide < ERR_MIN) begin
      err_sat = ERR_MIN[ADC_WIDTH-1:0];
    end else begin
      err_sat = err_wide[ADC_WIDTH-1:0];
    end
  end

  // Sample capture, error pair update, strobe and sticky overrun flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_reg     <= '0;
      setpoint_reg   <= '0;
      cur_error_reg  <= '0;
      prev_error_reg <= '0;
      first_reg      <= 1'b1;
      strobe_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
    end else if (!loop_enable) begin
      // Errors are deliberately held so downstream still sees the last pair.
      first_reg   <= 1'b1;
      strobe_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      strobe_reg <= strobe_next;
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end
      if (accept) begin
        sample_reg   <= adc_data;
        setpoint_reg <= setpoint;
      end
      if (calc_fire) begin
        // First sample after (re)arming seeds both so the first derivative is 0.
        prev_error_reg <= first_reg ? err_sat : cur_error_reg;
        cur_error_reg  <= err_sat;
        first_reg      <= 1'b0;
      end
    end
  end

  assign cur_error    = cur_error_reg;
  assign prev_error   = prev_error_reg;
  assign deriv_enable = strobe_reg;
  assign integ_enable = strobe_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_pid_error_tracker.sv
// Bench for pid_error_tracker: a DECIM=1 instance and a DECIM=4 instance.
// Stimulus pushes hand-computed error pairs; monitors pop them on each strobe.
`timescale 1ns/1ps
module tb_pid_error_tracker;

  logic clk;
  logic n_rst;

  logic       loop_enable_a, adc_valid_a;
  logic [7:0] adc_data_a, setpoint_a, cur_a, prev_a;
  logic       deriv_a, integ_a, busy_a, overrun_a;

  logic       loop_enable_b, adc_valid_b;
  logic [7:0] adc_data_b, setpoint_b, cur_b, prev_b;
  logic       deriv_b, integ_b, busy_b, overrun_b;

  typedef struct packed {
    logic [7:0] cur;
    logic [7:0] prev;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int tests = 0;
  int fails = 0;
  int pushes_a = 0, pushes_b = 0;
  int strobes_a = 0, strobes_b = 0;
  logic last_deriv_a = 1'b0;
  logic last_deriv_b = 1'b0;

  pid_error_tracker #(.ADC_WIDTH(8), .DECIM(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .loop_enable(loop_enable_a),
    .adc_valid(adc_valid_a), .adc_data(adc_data_a), .setpoint(setpoint_a),
    .cur_error(cur_a), .prev_error(prev_a), .deriv_enable(deriv_a),
    .integ_enable(integ_a), .busy(busy_a), .overrun(overrun_a)
  );

  pid_error_tracker #(.ADC_WIDTH(8), .DECIM(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .loop_enable(loop_enable_b),
    .adc_valid(adc_valid_b), .adc_data(adc_data_b), .setpoint(setpoint_b),
    .cur_error(cur_b), .prev_error(prev_b), .deriv_enable(deriv_b),
    .integ_enable(integ_b), .busy(busy_b), .overrun(overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for instance A: every strobe must match the next queued pair.
  always begin
    @(posedge clk);
    #1;
    if (deriv_a || integ_a) begin
      check("a_integ_eq_deriv", integ_a, deriv_a);
      check("a_no_back_to_back", last_deriv_a, 1'b0);
      if (qa.size() == 0) begin
        check("a_unexpected_strobe", 1, 0);
      end else begin
        ea = qa.pop_front();
        check("a_strobe_cur", cur_a, ea.cur);
        check("a_strobe_prev", prev_a, ea.prev);
        $display("[TB] A strobe cur=0x%02h prev=0x%02h", cur_a, prev_a);
      end
      strobes_a++;
    end
    last_deriv_a = deriv_a;
  end

  // Monitor for instance B.
  always begin
    @(posedge clk);
    #1;
    if (deriv_b || integ_b) begin
      check("b_integ_eq_deriv", integ_b, deriv_b);
      check("b_no_back_to_back", last_deriv_b, 1'b0);
      if (qb.size() == 0) begin
        check("b_unexpected_strobe", 1, 0);
      end else begin
        eb = qb.pop_front();
        check("b_strobe_cur", cur_b, eb.cur);
        check("b_strobe_prev", prev_b, eb.prev);
        $display("[TB] B strobe cur=0x%02h prev=0x%02h", cur_b, prev_b);
      end
      strobes_b++;
    end
    last_deriv_b = deriv_b;
  end

  // One full accepted sample on instance A with E0..E3 timing checks.
  task automatic send_a(input logic [7:0] sp, input logic [7:0] adc,
                        input logic [7:0] exp_c, input logic [7:0] exp_p);
    setpoint_a  = sp;
    adc_data_a  = adc;
    adc_valid_a = 1'b1;
    qa.push_back('{cur: exp_c, prev: exp_p});
    pushes_a++;
    step();  // E0
    adc_valid_a = 1'b0;
    check("a_busy_e0", busy_a, 1'b1);
    step();  // E1
    check("a_cur_e1", cur_a, exp_c);
    check("a_prev_e1", prev_a, exp_p);
    check("a_busy_e1", busy_a, 1'b1);
    check("a_nostrobe_e1", deriv_a, 1'b0);
    step();  // E2: strobe high, checked by monitor
    check("a_strobe_e2", deriv_a, 1'b1);
    check("a_busy_e2", busy_a, 1'b0);
    step();  // E3
    check("a_strobe_off_e3", deriv_a, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    loop_enable_a = 1'b0; adc_valid_a = 1'b0; adc_data_a = '0; setpoint_a = '0;
    loop_enable_b = 1'b0; adc_valid_b = 1'b0; adc_data_b = '0; setpoint_b = '0;
    #3;
    check("rst_cur", cur_a, 8'h00);
    check("rst_prev", prev_a, 8'h00);
    check("rst_strobe", {deriv_a, integ_a}, 2'b00);
    check("rst_busy", busy_a, 1'b0);
    check("rst_overrun", overrun_a, 1'b0);
    step();
    n_rst = 1'b1;
    loop_enable_a = 1'b1;
    step();

    // First sample, normal second sample, then both saturation limits.
    send_a(8'h80, 8'h70, 8'h10, 8'h10);
    send_a(8'h80, 8'h90, 8'hF0, 8'h10);
    send_a(8'hFF, 8'h00, 8'h7F, 8'hF0);
    send_a(8'h00, 8'hFF, 8'h80, 8'h7F);

    // Overrun: valid held across E0 and E1; only the E0 sample is processed.
    setpoint_a = 8'h40; adc_data_a = 8'h30; adc_valid_a = 1'b1;
    qa.push_back('{cur: 8'h10, prev: 8'h80});
    pushes_a++;
    step();  // E0
    check("ovr_e0", overrun_a, 1'b0);
    adc_data_a = 8'h00;
    step();  // E1
    adc_valid_a = 1'b0;
    check("ovr_e1", overrun_a, 1'b1);
    check("ovr_cur", cur_a, 8'h10);
    step();
    step();
    check("ovr_sticky", overrun_a, 1'b1);
    loop_enable_a = 1'b0;
    step();
    loop_enable_a = 1'b1;
    check("ovr_cleared", overrun_a, 1'b0);
    check("hold_cur_loop_off", cur_a, 8'h10);

    // Re-armed: next sample treated as first.
    send_a(8'h20, 8'h25, 8'hFB, 8'hFB);

    // Abort during STROBE: errors updated at E1, strobe suppressed.
    setpoint_a = 8'h10; adc_data_a = 8'h00; adc_valid_a = 1'b1;
    step();  // E0
    adc_valid_a = 1'b0;
    step();  // E1
    check("abort_cur_e1", cur_a, 8'h10);
    check("abort_prev_e1", prev_a, 8'hFB);
    loop_enable_a = 1'b0;
    step();  // E2 with loop disabled
    check("abort_no_strobe", deriv_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_cur_held", cur_a, 8'h10);
    check("abort_prev_held", prev_a, 8'hFB);
    loop_enable_a = 1'b1;
    step();
    send_a(8'h50, 8'h48, 8'h08, 8'h08);

    // Asynchronous reset in the middle of CALC.
    setpoint_a = 8'h60; adc_data_a = 8'h00; adc_valid_a = 1'b1;
    step();  // E0, now in CALC
    adc_valid_a = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_cur", cur_a, 8'h00);
    check("arst_prev", prev_a, 8'h00);
    check("arst_busy", busy_a, 1'b0);
    check("arst_strobe", {deriv_a, integ_a}, 2'b00);
    check("arst_overrun", overrun_a, 1'b0);
    step();
    n_rst = 1'b1;
    step();
    step();
    step();

    // DECIM=4: eight pulses, only the 4th and 8th are processed.
    loop_enable_b = 1'b1;
    setpoint_b = 8'h80;
    step();
    for (int k = 1; k <= 8; k++) begin
      adc_data_b  = 8'(8'h80 - 4 * k);
      adc_valid_b = 1'b1;
      if (k == 4) begin
        qb.push_back('{cur: 8'h10, prev: 8'h10});
        pushes_b++;
      end
      if (k == 8) begin
        qb.push_back('{cur: 8'h20, prev: 8'h10});
        pushes_b++;
      end
      step();
      adc_valid_b = 1'b0;
      check("b_busy_after_pulse", busy_b, (k % 4 == 0) ? 1'b1 : 1'b0);
      step();
      step();
      step();
    end
    check("b_overrun", overrun_b, 1'b0);

    for (int i = 0; i < 5; i++) step();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    check("a_strobe_count", strobes_a, pushes_a);
    check("b_strobe_count", strobes_b, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
